// File: rtl/sensor_mem_ctrl.sv
// Single-port sensor sample/config memory with req/ready handshake, registered
// read, address range checking and a zero-fill sweep after reset or on clear.
module sensor_mem_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clear,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              err,
  output logic              busy
);

  // state | meaning
  // INIT  | zero-fill sweep, one word per cycle; no requests accepted
  // IDLE  | ready for read/write requests
  typedef enum logic {INIT, IDLE} state_t;

  // ptr is one bit wider than addr so DEPTH == 2**ADDR_W is representable
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST    = (ADDR_W+1)'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   ptr, ptr_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              accept;
  logic              in_range;

  assign ready    = (state == IDLE);
  assign busy     = (state == INIT);
  assign accept   = req & ready;
  assign in_range = ({1'b0, addr} < DEPTH_W);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      INIT: begin
        if (clear) begin
          ptr_nxt = '0;
        end else if (ptr == LAST) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + 1'b1;
        end
      end
      IDLE: begin
        if (clear) begin
          state_nxt = INIT;
          ptr_nxt   = '0;
        end
      end
      default: begin
        state_nxt = INIT;
        ptr_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= INIT;
      ptr    <= '0;
      rvalid <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      rvalid <= accept & ~we;
      err    <= accept & ~in_range;
      if (accept && !we) begin
        rdata <= in_range ? mem[addr] : '0;
      end
    end
  end

  // Array has no reset; the sweep owns the write port whenever state is INIT
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[ptr[ADDR_W-1:0]] <= '0;
    end else if (accept && we && in_range) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: tb/tb_sensor_mem_ctrl.sv
// Directed bench for sensor_mem_ctrl: default 256x8, DEPTH=200 and 16x16
// instances share clock and reset; expected values are hand-computed constants.
module tb_sensor_mem_ctrl;

  logic clk;
  logic rst;

  // default instance: DATA_W=8, ADDR_W=8, DEPTH=256
  logic        req, we, clear;
  logic [7:0]  addr, wdata;
  logic        ready, rvalid, err, busy;
  logic [7:0]  rdata;

  // DEPTH=200 instance
  logic        req2, we2, clear2;
  logic [7:0]  addr2, wdata2;
  logic        ready2, rvalid2, err2, busy2;
  logic [7:0]  rdata2;

  // DATA_W=16, ADDR_W=4, DEPTH=16 instance
  logic        req3, we3, clear3;
  logic [3:0]  addr3;
  logic [15:0] wdata3;
  logic        ready3, rvalid3, err3, busy3;
  logic [15:0] rdata3;

  int n_tests;
  int n_fail;

  sensor_mem_ctrl u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .clear(clear), .ready(ready), .rdata(rdata), .rvalid(rvalid), .err(err),
    .busy(busy)
  );

  sensor_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(200)) u_d200 (
    .clk(clk), .rst(rst), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
    .clear(clear2), .ready(ready2), .rdata(rdata2), .rvalid(rvalid2), .err(err2),
    .busy(busy2)
  );

  sensor_mem_ctrl #(.DATA_W(16), .ADDR_W(4), .DEPTH(16)) u_w16 (
    .clk(clk), .rst(rst), .req(req3), .we(we3), .addr(addr3), .wdata(wdata3),
    .clear(clear3), .ready(ready3), .rdata(rdata3), .rvalid(rvalid3), .err(err3),
    .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic acc1(input logic w, input logic [7:0] a, input logic [7:0] d);
    req = 1'b1; we = w; addr = a; wdata = d;
    tick();
    req = 1'b0; we = 1'b0;
  endtask

  task automatic acc2(input logic w, input logic [7:0] a, input logic [7:0] d);
    req2 = 1'b1; we2 = w; addr2 = a; wdata2 = d;
    tick();
    req2 = 1'b0; we2 = 1'b0;
  endtask

  task automatic acc3(input logic w, input logic [3:0] a, input logic [15:0] d);
    req3 = 1'b1; we3 = w; addr3 = a; wdata3 = d;
    tick();
    req3 = 1'b0; we3 = 1'b0;
  endtask

  // counts edges until the default instance reports ready, bounded
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 400) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n, n2, n3;
    logic saw_strobe;
    n_tests = 0; n_fail = 0;
    rst = 1'b1;
    req = 0; we = 0; clear = 0; addr = 0; wdata = 0;
    req2 = 0; we2 = 0; clear2 = 0; addr2 = 0; wdata2 = 0;
    req3 = 0; we3 = 0; clear3 = 0; addr3 = 0; wdata3 = 0;

    #7;
    check_val("rst_ready",  32'(ready),  32'h0);
    check_val("rst_busy",   32'(busy),   32'h1);
    check_val("rst_rvalid", 32'(rvalid), 32'h0);
    check_val("rst_err",    32'(err),    32'h0);
    check_val("rst_rdata",  32'(rdata),  32'h0);

    #15;
    rst = 1'b0;
    n = 0; n2 = 0; n3 = 0;
    while (!ready && n < 400) begin
      tick();
      n++;
      if (n2 == 0 && ready2) n2 = n;
      if (n3 == 0 && ready3) n3 = n;
    end
    check_val("sweep_len_256", 32'(n),  32'd256);
    check_val("sweep_len_200", 32'(n2), 32'd200);
    check_val("sweep_len_16",  32'(n3), 32'd16);
    check_val("idle_busy",     32'(busy), 32'h0);

    acc1(1'b0, 8'h00, 8'h00);
    check_val("rd00_rvalid", 32'(rvalid), 32'h1);
    check_val("rd00_rdata",  32'(rdata),  32'h0);
    acc1(1'b0, 8'hFF, 8'h00);
    check_val("rdFF_rvalid", 32'(rvalid), 32'h1);
    check_val("rdFF_rdata",  32'(rdata),  32'h0);
    check_val("rdFF_err",    32'(err),    32'h0);

    acc1(1'b1, 8'h10, 8'hA5);
    check_val("wr10_rvalid", 32'(rvalid), 32'h0);
    acc1(1'b0, 8'h10, 8'h00);
    check_val("rd10_rdata",  32'(rdata),  32'hA5);
    check_val("rd10_rvalid", 32'(rvalid), 32'h1);
    tick();
    check_val("rd10_pulse",  32'(rvalid), 32'h0);
    check_val("rd10_hold",   32'(rdata),  32'hA5);

    acc1(1'b0, 8'h10, 8'h00);
    check_val("b2b0_rdata", 32'(rdata), 32'hA5);
    check_val("b2b0_rv",    32'(rvalid), 32'h1);
    acc1(1'b0, 8'h11, 8'h00);
    check_val("b2b1_rdata", 32'(rdata), 32'h00);
    check_val("b2b1_rv",    32'(rvalid), 32'h1);
    acc1(1'b0, 8'h10, 8'h00);
    check_val("b2b2_rdata", 32'(rdata), 32'hA5);
    check_val("b2b2_rv",    32'(rvalid), 32'h1);
    tick();
    check_val("b2b_end_rv", 32'(rvalid), 32'h0);

    // write with clear on the same edge
    clear = 1'b1;
    acc1(1'b1, 8'h20, 8'h77);
    clear = 1'b0;
    check_val("clr_busy",  32'(busy),  32'h1);
    check_val("clr_ready", 32'(ready), 32'h0);
    check_val("clr_err",   32'(err),   32'h0);
    wait_ready(n);
    check_val("clr_sweep_len", 32'(n), 32'd256);
    acc1(1'b0, 8'h20, 8'h00);
    check_val("clr_rd20", 32'(rdata), 32'h00);
    acc1(1'b0, 8'h10, 8'h00);
    check_val("clr_rd10", 32'(rdata), 32'h00);

    // read accepted on the clear edge returns pre-clear data
    acc1(1'b1, 8'h30, 8'h5A);
    clear = 1'b1;
    acc1(1'b0, 8'h30, 8'h00);
    clear = 1'b0;
    check_val("clr_rd_pre", 32'(rdata), 32'h5A);
    check_val("clr_rd_rv",  32'(rvalid), 32'h1);

    // clear at sweep cycle 100 restarts; requests during the sweep are ignored
    for (int i = 0; i < 100; i++) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    saw_strobe = 1'b0;
    n = 0;
    req = 1'b1; we = 1'b0; addr = 8'hFF;
    while (!ready && n < 400) begin
      tick();
      n++;
      if (rvalid || err) saw_strobe = 1'b1;
    end
    req = 1'b0;
    check_val("restart_len",  32'(n), 32'd256);
    check_val("init_no_strb", 32'(saw_strobe), 32'h0);
    acc1(1'b0, 8'h30, 8'h00);
    check_val("restart_rd30", 32'(rdata), 32'h00);

    // rst at sweep cycle 50
    acc1(1'b1, 8'h40, 8'hC3);
    acc1(1'b0, 8'h40, 8'h00);
    check_val("pre_rst_rd40", 32'(rdata), 32'hC3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    rst = 1'b1;
    #1;
    check_val("mid_rst_rdata", 32'(rdata), 32'h0);
    check_val("mid_rst_ready", 32'(ready), 32'h0);
    check_val("mid_rst_busy",  32'(busy),  32'h1);
    check_val("mid_rst_rv",    32'(rvalid), 32'h0);
    tick();
    rst = 1'b0;
    wait_ready(n);
    check_val("post_rst_len", 32'(n), 32'd256);

    // DEPTH=200 instance
    acc2(1'b1, 8'd200, 8'h55);
    check_val("d200_wr_oor_err", 32'(err2),    32'h1);
    check_val("d200_wr_oor_rv",  32'(rvalid2), 32'h0);
    tick();
    check_val("d200_err_pulse",  32'(err2),    32'h0);
    acc2(1'b1, 8'd199, 8'h3C);
    check_val("d200_wr199_err",  32'(err2),    32'h0);
    acc2(1'b0, 8'd199, 8'h00);
    check_val("d200_rd199",      32'(rdata2),  32'h3C);
    check_val("d200_rd199_err",  32'(err2),    32'h0);
    check_val("d200_rd199_rv",   32'(rvalid2), 32'h1);
    acc2(1'b0, 8'd250, 8'h00);
    check_val("d200_rd250",      32'(rdata2),  32'h00);
    check_val("d200_rd250_rv",   32'(rvalid2), 32'h1);
    check_val("d200_rd250_err",  32'(err2),    32'h1);
    acc2(1'b0, 8'd0, 8'h00);
    check_val("d200_rd0",        32'(rdata2),  32'h00);
    check_val("d200_rd0_err",    32'(err2),    32'h0);

    // DATA_W=16, DEPTH=16 instance
    acc3(1'b1, 4'hF, 16'hBEEF);
    check_val("w16_wr_rv",  32'(rvalid3), 32'h0);
    acc3(1'b0, 4'hF, 16'h0000);
    check_val("w16_rdF",    32'(rdata3),  32'hBEEF);
    check_val("w16_rdF_rv", 32'(rvalid3), 32'h1);
    check_val("w16_rdF_err", 32'(err3),   32'h0);
    acc3(1'b0, 4'hE, 16'h0000);
    check_val("w16_rdE",    32'(rdata3),  32'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sensor_mem_ctrl.md
Name: sensor_mem_ctrl

Overview:
Parametrised single-port synchronous memory for sensor-node sample and config storage. It replaces the fixed 256x8 tri-state memory with separate read and write data buses, a req/ready handshake, a registered read with a valid strobe, and address range checking. A built-in clear sequencer zeroes the whole array after reset and on command, so downstream logic never reads stale contents.

Parameters:
DATA_W, 8, data word width in bits (>=1)
ADDR_W, 8, address width in bits (>=1)
DEPTH, 256, number of words (1 .. 2**ADDR_W); need not be a power of two

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
req  in  1  access request
we  in  1  1 = write, 0 = read; qualified by req
addr  in  ADDR_W  word address
wdata  in  DATA_W  write data
clear  in  1  start a zero-fill sweep (single-cycle pulse or level)
ready  out  1  memory can accept a request this cycle
rdata  out  DATA_W  read data, registered
rvalid  out  1  one-cycle pulse: rdata is valid
err  out  1  one-cycle pulse: last accepted request had addr >= DEPTH
busy  out  1  clear sweep in progress

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk, rst).
- Reset values: state=INIT, sweep ptr=0, ready=0, busy=1, rvalid=0, err=0, rdata=0.
- States:
  - INIT: each cycle writes 0 to mem[ptr] and increments ptr. On the cycle ptr==DEPTH-1 is written, next state is IDLE. The sweep takes exactly DEPTH cycles after rst deasserts. ready=0 and busy=1 throughout.
  - IDLE: ready=1, busy=0.
- ready and busy are decoded from registered state only; there is no combinational path from inputs.
- Accept condition: req & ready on a rising edge. req while ready=0 is ignored and not queued.
- Write (we=1), addr<DEPTH: mem[addr]<=wdata on the accepting edge. No rvalid.
- Read (we=0), addr<DEPTH: on the accepting edge rdata<=mem[addr] and rvalid=1 for one cycle. Latency 1 cycle. Back-to-back reads give rvalid on consecutive cycles.
- rdata holds its last value when no read is accepted; it is not zeroed.
- Out of range (addr>=DEPTH):
  - Write: memory unchanged; err=1 for one cycle.
  - Read: rdata<=0, rvalid=1, err=1 for one cycle.
- clear in IDLE: the next state is INIT with ptr=0. A request accepted on the same edge completes normally (the write lands, the read returns pre-clear data). The sweep then zeroes everything.
- clear during INIT restarts the sweep at ptr=0.
- rst asserted mid-sweep or mid-access: immediate return to reset values. The array contents are undefined until the sweep rewrites them.
- Array: DEPTH entries of DATA_W. ptr is ADDR_W+1 bits wide so DEPTH=2**ADDR_W terminates correctly.
- err and rvalid never assert during INIT.

Test Plan:
- Reset release, default parameters -> busy=1 and ready=0 for exactly 256 cycles, then ready=1. A read of addr 0x00 and of 0xFF returns 0x00 with rvalid one cycle after the accepting edge.
- Write 0xA5 to 0x10, then read 0x10 on the next cycle -> rdata=0xA5, rvalid high for 1 cycle. Reads of 0x10, 0x11, 0x10 back-to-back -> 0xA5, 0x00, 0xA5 with rvalid on 3 consecutive cycles.
- DEPTH=200: write 0x55 to addr 200 -> err pulse, no rvalid. Read addr 250 -> rdata=0x00, rvalid=1, err=1. Read addr 199 after writing 0x3C -> 0x3C, err=0.
- Write 0x77 to 0x20 with clear asserted on the same edge -> write accepted, then busy=1 for 256 cycles. A later read of 0x20 returns 0x00.
- Assert clear again at sweep cycle 100 -> the sweep restarts, and ready rises 256 cycles after the second clear. Assert rst at sweep cycle 50 -> outputs return to reset values immediately, and ready rises 256 cycles after release.
- DATA_W=16, ADDR_W=4, DEPTH=16: write 0xBEEF to 0xF and read it back -> 0xBEEF. The sweep lasts 16 cycles.
